// File: rtl/fmps_read_link_multi.sv
// FMPS cell-link receiver: validates multi-word packets, commits good payloads to a per-index ping-pong RAM.
// Optional saturating error counters are built only when FMPS_READ_LINK_ERROR_COUNTERS_EN is defined.
module fmps_read_link_multi #(
  parameter int unsigned INDEX_WIDTH   = 5,
  parameter int unsigned DATA_WORDS    = 1,
  parameter logic [15:0] MAGIC         = 16'hB6CF,
  parameter int unsigned COUNTER_WIDTH = 16,
  localparam int unsigned WORD_BITS    = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1
) (
  input  logic                           auroraClk,
  input  logic                           auroraResetN,
  input  logic                           FAstrobe,
  input  logic                           allFMPSpresent,
  input  logic                           TVALID,
  input  logic                           TLAST,
  input  logic [31:0]                    TDATA,
  output logic                           statusStrobe,
  output logic [2:0]                     statusCode,
  output logic                           statusFMPSenabled,
  output logic [INDEX_WIDTH-1:0]         statusFMPSindex,
  output logic [(1<<INDEX_WIDTH)-1:0]    fmpsBitmap,
  output logic [INDEX_WIDTH:0]           fmpsCounter,
  input  logic [INDEX_WIDTH+WORD_BITS-1:0] readoutAddress,
  output logic [31:0]                    readoutData,
  output logic [COUNTER_WIDTH-1:0]       badHeaderCount,
  output logic [COUNTER_WIDTH-1:0]       badSizeCount,
  output logic [COUNTER_WIDTH-1:0]       badPacketCount,
  output logic [COUNTER_WIDTH-1:0]       duplicateCount
);

  localparam int unsigned N_SRC     = 1 << INDEX_WIDTH;
  localparam int unsigned ADDR_BITS = INDEX_WIDTH + WORD_BITS;
  localparam int unsigned RAM_DEPTH = 1 << (ADDR_BITS + 1);

  localparam logic [1:0] AWAIT_HEADER = 2'd0;
  localparam logic [1:0] AWAIT_DATA   = 2'd1;
  localparam logic [1:0] AWAIT_LAST   = 2'd2;

  localparam logic [2:0] ST_SUCCESS    = 3'd0;
  localparam logic [2:0] ST_BAD_HEADER = 3'd1;
  localparam logic [2:0] ST_BAD_SIZE   = 3'd2;
  localparam logic [2:0] ST_BAD_PACKET = 3'd3;
  localparam logic [2:0] ST_DUPLICATE  = 3'd4;

  logic [1:0]             state_q, state_d;
  logic [WORD_BITS-1:0]   word_cnt_q, word_cnt_d;
  logic                   invalid_q, invalid_d;
  logic                   strobe_q, strobe_d;
  logic [2:0]             code_q, code_d;
  logic                   enabled_q, enabled_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [N_SRC-1:0]       bitmap_q, bitmap_d;
  logic [N_SRC-1:0]       page_sel_q, page_sel_d;
  logic [INDEX_WIDTH:0]   counter_q, counter_d;
  logic [31:0]            rd_data_q, rd_data_d;

  logic                   ram_we_c;
  logic [ADDR_BITS:0]     ram_waddr_c;
  logic [31:0]            ram_wdata_c;
  logic                   hdr_magic_c;
  logic                   last_word_c;
  logic [INDEX_WIDTH-1:0] rd_index_c;
  logic [WORD_BITS-1:0]   rd_word_c;

  logic [31:0] mem [RAM_DEPTH];

  assign hdr_magic_c = (TDATA[31:16] == MAGIC);
  assign last_word_c = (word_cnt_q == WORD_BITS'(DATA_WORDS - 1));

  // Packet framing FSM; payload lands in the staging page (inverse of pageSel)
  always_comb begin : next_state
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    invalid_d   = invalid_q;
    strobe_d    = 1'b0;
    code_d      = code_q;
    enabled_d   = enabled_q;
    index_d     = index_q;
    bitmap_d    = bitmap_q;
    counter_d   = counter_q;
    page_sel_d  = page_sel_q;
    ram_we_c    = 1'b0;
    ram_waddr_c = {~page_sel_q[index_q], index_q, word_cnt_q};
    ram_wdata_c = TDATA;

    if (FAstrobe) begin
      state_d   = AWAIT_HEADER;
      bitmap_d  = '0;
      counter_d = '0;
    end else if (TVALID) begin
      case (state_q)
        AWAIT_HEADER: begin
          if (hdr_magic_c) begin
            enabled_d  = TDATA[15];
            index_d    = TDATA[10 +: INDEX_WIDTH];
            word_cnt_d = '0;
            invalid_d  = 1'b0;
            if (TLAST) begin
              strobe_d = 1'b1;
              code_d   = ST_BAD_SIZE;
            end else begin
              state_d = AWAIT_DATA;
            end
          end else begin
            strobe_d = 1'b1;
            code_d   = ST_BAD_HEADER;
            if (!TLAST) state_d = AWAIT_LAST;
          end
        end
        AWAIT_DATA: begin
          ram_we_c   = 1'b1;
          word_cnt_d = word_cnt_q + WORD_BITS'(1);
          invalid_d  = invalid_q | TDATA[31];
          if (TLAST != last_word_c) begin
            strobe_d = 1'b1;
            code_d   = ST_BAD_SIZE;
            state_d  = TLAST ? AWAIT_HEADER : AWAIT_LAST;
          end else if (TLAST) begin
            strobe_d = 1'b1;
            state_d  = AWAIT_HEADER;
            if (TDATA[30]) begin
              code_d = ST_BAD_PACKET;
            end else if (bitmap_q[index_q]) begin
              code_d = ST_DUPLICATE;
            end else begin
              code_d = ST_SUCCESS;
              if (counter_q != '1) counter_d = counter_q + (INDEX_WIDTH+1)'(1);
              // Invalid payloads still count but are never exposed to readers
              if (!invalid_d && !allFMPSpresent) begin
                page_sel_d[index_q] = ~page_sel_q[index_q];
                bitmap_d[index_q]   = 1'b1;
              end
            end
          end
        end
        AWAIT_LAST: begin
          if (TLAST) state_d = AWAIT_HEADER;
        end
        default: state_d = AWAIT_HEADER;
      endcase
    end
  end

  // Readout always targets the committed page; out-of-range word fields read zero
  always_comb begin : readout
    rd_index_c = readoutAddress[WORD_BITS +: INDEX_WIDTH];
    rd_word_c  = readoutAddress[WORD_BITS-1:0];
    rd_data_d  = '0;
    if (32'(rd_word_c) < DATA_WORDS) rd_data_d = mem[{page_sel_q[rd_index_c], readoutAddress}];
  end

  always_ff @(posedge auroraClk or negedge auroraResetN) begin : regs
    if (!auroraResetN) begin
      state_q    <= AWAIT_HEADER;
      word_cnt_q <= '0;
      invalid_q  <= 1'b0;
      strobe_q   <= 1'b0;
      code_q     <= ST_SUCCESS;
      enabled_q  <= 1'b0;
      index_q    <= '0;
      bitmap_q   <= '0;
      page_sel_q <= '0;
      counter_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      invalid_q  <= invalid_d;
      strobe_q   <= strobe_d;
      code_q     <= code_d;
      enabled_q  <= enabled_d;
      index_q    <= index_d;
      bitmap_q   <= bitmap_d;
      page_sel_q <= page_sel_d;
      counter_q  <= counter_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Payload RAM is intentionally not reset
  always_ff @(posedge auroraClk) begin : ram_write
    if (ram_we_c) mem[ram_waddr_c] <= ram_wdata_c;
  end

  assign statusStrobe      = strobe_q;
  assign statusCode        = code_q;
  assign statusFMPSenabled = enabled_q;
  assign statusFMPSindex   = index_q;
  assign fmpsBitmap        = bitmap_q;
  assign fmpsCounter       = counter_q;
  assign readoutData       = rd_data_q;

`ifdef FMPS_READ_LINK_ERROR_COUNTERS_EN
  logic [COUNTER_WIDTH-1:0] bad_header_cnt_q, bad_header_cnt_d;
  logic [COUNTER_WIDTH-1:0] bad_size_cnt_q, bad_size_cnt_d;
  logic [COUNTER_WIDTH-1:0] bad_packet_cnt_q, bad_packet_cnt_d;
  logic [COUNTER_WIDTH-1:0] duplicate_cnt_q, duplicate_cnt_d;

  // Saturating per-code error counters, cleared only by reset
  always_comb begin : err_next
    bad_header_cnt_d = bad_header_cnt_q;
    bad_size_cnt_d   = bad_size_cnt_q;
    bad_packet_cnt_d = bad_packet_cnt_q;
    duplicate_cnt_d  = duplicate_cnt_q;
    if (strobe_d) begin
      case (code_d)
        ST_BAD_HEADER: if (~&bad_header_cnt_q) bad_header_cnt_d = bad_header_cnt_q + COUNTER_WIDTH'(1);
        ST_BAD_SIZE:   if (~&bad_size_cnt_q)   bad_size_cnt_d   = bad_size_cnt_q + COUNTER_WIDTH'(1);
        ST_BAD_PACKET: if (~&bad_packet_cnt_q) bad_packet_cnt_d = bad_packet_cnt_q + COUNTER_WIDTH'(1);
        ST_DUPLICATE:  if (~&duplicate_cnt_q)  duplicate_cnt_d  = duplicate_cnt_q + COUNTER_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge auroraClk or negedge auroraResetN) begin : err_regs
    if (!auroraResetN) begin
      bad_header_cnt_q <= '0;
      bad_size_cnt_q   <= '0;
      bad_packet_cnt_q <= '0;
      duplicate_cnt_q  <= '0;
    end else begin
      bad_header_cnt_q <= bad_header_cnt_d;
      bad_size_cnt_q   <= bad_size_cnt_d;
      bad_packet_cnt_q <= bad_packet_cnt_d;
      duplicate_cnt_q  <= duplicate_cnt_d;
    end
  end

  assign badHeaderCount = bad_header_cnt_q;
  assign badSizeCount   = bad_size_cnt_q;
  assign badPacketCount = bad_packet_cnt_q;
  assign duplicateCount = duplicate_cnt_q;
`else
  assign badHeaderCount = '0;
  assign badSizeCount   = '0;
  assign badPacketCount = '0;
  assign duplicateCount = '0;
`endif

endmodule

// File: tb/tb_fmps_read_link_multi.sv
// Bench for fmps_read_link_multi (DATA_WORDS=4): directed and random packets against a packet-level model.
// Error-counter expectations follow FMPS_READ_LINK_ERROR_COUNTERS_EN.
module tb_fmps_read_link_multi;

  localparam int IW = 5;
  localparam int DW = 4;
  localparam int NS = 32;

  logic        clk = 1'b0;
  logic        auroraResetN, FAstrobe, allFMPSpresent, TVALID, TLAST;
  logic [31:0] TDATA;
  logic        statusStrobe, statusFMPSenabled;
  logic [2:0]  statusCode;
  logic [IW-1:0] statusFMPSindex;
  logic [NS-1:0] fmpsBitmap;
  logic [IW:0]   fmpsCounter;
  logic [IW+1:0] readoutAddress;
  logic [31:0]   readoutData;
  logic [15:0]   badHeaderCount, badSizeCount, badPacketCount, duplicateCount;

  fmps_read_link_multi #(.INDEX_WIDTH(IW), .DATA_WORDS(DW)) dut (
    .auroraClk(clk), .auroraResetN(auroraResetN), .FAstrobe(FAstrobe),
    .allFMPSpresent(allFMPSpresent), .TVALID(TVALID), .TLAST(TLAST), .TDATA(TDATA),
    .statusStrobe(statusStrobe), .statusCode(statusCode),
    .statusFMPSenabled(statusFMPSenabled), .statusFMPSindex(statusFMPSindex),
    .fmpsBitmap(fmpsBitmap), .fmpsCounter(fmpsCounter),
    .readoutAddress(readoutAddress), .readoutData(readoutData),
    .badHeaderCount(badHeaderCount), .badSizeCount(badSizeCount),
    .badPacketCount(badPacketCount), .duplicateCount(duplicateCount)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]   m_mem [NS][DW];
  bit            m_known [NS];
  logic [NS-1:0] m_bitmap;
  int            m_counter;
  logic [IW-1:0] m_idx;
  logic          m_en;
  int            m_err [4];
  logic [31:0]   pkt [$];
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int k);
`ifdef FMPS_READ_LINK_ERROR_COUNTERS_EN
    return 16'(m_err[k]);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    m_bitmap = '0; m_counter = 0; m_idx = '0; m_en = 1'b0;
    for (int k = 0; k < 4; k++) m_err[k] = 0;
    for (int k = 0; k < NS; k++) m_known[k] = 1'b0;
  endtask

  task automatic chk_counts();
    chk("bad_header_count", 64'(badHeaderCount), 64'(exp_cnt(0)));
    chk("bad_size_count",   64'(badSizeCount),   64'(exp_cnt(1)));
    chk("bad_packet_count", 64'(badPacketCount), 64'(exp_cnt(2)));
    chk("duplicate_count",  64'(duplicateCount), 64'(exp_cnt(3)));
  endtask

  // Outcome is decided at packet level from the beat list, then checked beat by beat
  task automatic send_pkt();
    int n = pkt.size();
    int dec, code;
    bit magic, succ, commit, inval;
    logic [IW-1:0] pidx;
    int ra_i, ra_w;
    magic = (pkt[0][31:16] == 16'hB6CF);
    pidx = pkt[0][14:10];
    succ = 0; commit = 0;
    if (!magic) begin dec = 0; code = 1; end
    else if (n == 1) begin dec = 0; code = 2; end
    else if (n - 1 != DW) begin dec = (n - 1 < DW) ? n - 1 : DW; code = 2; end
    else begin
      dec = DW; inval = 0;
      for (int w = 1; w <= DW; w++) inval |= pkt[w][31];
      if (pkt[DW][30]) code = 3;
      else if (m_bitmap[pidx]) code = 4;
      else begin code = 0; succ = 1; commit = !inval && !allFMPSpresent; end
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      TVALID = 1'b1; TDATA = pkt[i]; TLAST = (i == n - 1);
      @(posedge clk); #1;
      ra_i = int'(readoutAddress[IW+1:2]); ra_w = int'(readoutAddress[1:0]);
      if (m_known[ra_i]) chk("readout_during_pkt", 64'(readoutData), 64'(m_mem[ra_i][ra_w]));
      if (i == 0 && magic) begin m_idx = pidx; m_en = pkt[0][15]; end
      chk("strobe", 64'(statusStrobe), 64'(i == dec));
      if (i == dec) begin
        if (succ && m_counter < 63) m_counter++;
        if (commit) begin
          m_bitmap[pidx] = 1'b1;
          m_known[pidx] = 1'b1;
          for (int w = 0; w < DW; w++) m_mem[pidx][w] = pkt[w+1];
        end
        if (code != 0) m_err[code-1]++;
        chk("status_code", 64'(statusCode), 64'(code));
        chk("status_index", 64'(statusFMPSindex), 64'(m_idx));
        chk("status_enabled", 64'(statusFMPSenabled), 64'(m_en));
        chk("bitmap", 64'(fmpsBitmap), 64'(m_bitmap));
        chk("counter", 64'(fmpsCounter), 64'(m_counter));
        chk_counts();
      end
    end
  endtask

  task automatic send_partial();
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge clk);
      TVALID = 1'b1; TDATA = pkt[i]; TLAST = 1'b0;
      @(posedge clk); #1;
      if (i == 0) begin m_idx = pkt[0][14:10]; m_en = pkt[0][15]; end
      chk("strobe_partial", 64'(statusStrobe), 64'd0);
    end
  endtask

  task automatic idle();
    @(negedge clk); TVALID = 1'b0; TLAST = 1'b0;
    @(posedge clk); #1;
    chk("strobe_idle", 64'(statusStrobe), 64'd0);
  endtask

  task automatic rd(input int idx, input int w, input logic [31:0] exp);
    @(negedge clk); TVALID = 1'b0; TLAST = 1'b0;
    readoutAddress = {5'(idx), 2'(w)};
    @(posedge clk); #1;
    chk("readout", 64'(readoutData), 64'(exp));
    chk("strobe_idle", 64'(statusStrobe), 64'd0);
  endtask

  task automatic rd_all(input int idx);
    if (m_known[idx]) for (int w = 0; w < DW; w++) rd(idx, w, m_mem[idx][w]);
  endtask

  task automatic fa(input bit with_valid);
    @(negedge clk);
    FAstrobe = 1'b1; TVALID = with_valid; TDATA = 32'($urandom); TLAST = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    m_bitmap = '0; m_counter = 0;
    chk("fa_bitmap", 64'(fmpsBitmap), 64'd0);
    chk("fa_counter", 64'(fmpsCounter), 64'd0);
    chk("fa_strobe", 64'(statusStrobe), 64'd0);
    @(negedge clk); FAstrobe = 1'b0; TVALID = 1'b0; TLAST = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_strobe", 64'(statusStrobe), 64'd0);
    chk("rst_code", 64'(statusCode), 64'd0);
    chk("rst_index", 64'(statusFMPSindex), 64'd0);
    chk("rst_enabled", 64'(statusFMPSenabled), 64'd0);
    chk("rst_bitmap", 64'(fmpsBitmap), 64'd0);
    chk("rst_counter", 64'(fmpsCounter), 64'd0);
    chk("rst_readout", 64'(readoutData), 64'd0);
    chk_counts();
  endtask

  initial begin
    int kind, idx, nw;
    logic [31:0] h;
    auroraResetN = 1'b0; FAstrobe = 1'b0; allFMPSpresent = 1'b0;
    TVALID = 1'b0; TLAST = 1'b0; TDATA = '0; readoutAddress = '0;
    model_reset();
    #12;
    chk_reset_values();
    @(negedge clk); auroraResetN = 1'b1;

    // Basic good packet for index 3
    pkt = '{32'hB6CF_0C00, 32'd1, 32'd2, 32'd3, 32'd4};
    send_pkt();
    idle();
    rd_all(3);

    // Invalid payload: counted as success but not committed
    fa(1'b0);
    pkt = '{32'hB6CF_0C00, 32'd10, 32'h8000_0005, 32'd12, 32'd13};
    send_pkt();
    rd_all(3);

    // Short packet
    pkt = '{32'hB6CF_0C00, 32'd20, 32'd21};
    send_pkt();
    rd_all(3);

    // Bad header discarded to TLAST, then a zero-gap good packet for index 7
    pkt = '{32'h1234_0000, 32'd5, 32'd6, 32'd7};
    send_pkt();
    pkt = '{32'hB6CF_1C00, 32'h11, 32'h22, 32'h33, 32'h44};
    send_pkt();
    rd_all(7);

    // Duplicate for index 7; first packet wins, then a new FA cycle commits a third
    fa(1'b0);
    pkt = '{32'hB6CF_9C00, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    send_pkt();
    pkt = '{32'hB6CF_1C00, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
    send_pkt();
    rd_all(7);
    fa(1'b0);
    rd(7, 0, m_mem[7][0]);
    pkt = '{32'hB6CF_1C00, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
    send_pkt();
    rd_all(7);

    // FA strobe mid-payload aborts silently
    pkt = '{32'hB6CF_2400, 32'hD0, 32'hD1};
    send_partial();
    fa(1'b1);
    pkt = '{32'hB6CF_2400, 32'hE0, 32'hE1, 32'hE2, 32'hE3};
    send_pkt();
    rd_all(9);

    // Randomized traffic
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 11);
      idx  = $urandom_range(0, 7);
      h = {16'hB6CF, 1'($urandom_range(0, 1)), 5'(idx), 10'($urandom)};
      if (kind == 0) h[31:16] = 16'hB6CF ^ 16'($urandom_range(1, 65535));
      nw = DW;
      if (kind == 1) nw = 0;
      if (kind == 2) nw = $urandom_range(1, DW - 1);
      if (kind == 3) nw = $urandom_range(DW + 1, DW + 2);
      pkt.delete();
      pkt.push_back(h);
      for (int w = 0; w < nw; w++) pkt.push_back(32'($urandom) & 32'h3FFF_FFFF);
      if (kind == 4) pkt[DW] = pkt[DW] | 32'h4000_0000;
      if (kind == 5) pkt[$urandom_range(1, DW)] |= 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) fa(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); TVALID = 1'b0; TLAST = 1'b0;
        allFMPSpresent = ~allFMPSpresent;
      end
      send_pkt();
      repeat ($urandom_range(0, 2)) idle();
      if ($urandom_range(0, 3) == 0) rd_all($urandom_range(0, 7));
    end
    @(negedge clk); allFMPSpresent = 1'b0; TVALID = 1'b0;

    // Asynchronous reset mid-packet
    fa(1'b0);
    pkt = '{32'hB6CF_8800, 32'h55, 32'h66, 32'h77, 32'h88};
    send_pkt();
    rd(2, 1, m_mem[2][1]);
    pkt = '{32'hB6CF_A400, 32'h99};
    send_partial();
    #2;
    auroraResetN = 1'b0; TVALID = 1'b0;
    #1;
    model_reset();
    chk_reset_values();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    @(negedge clk); auroraResetN = 1'b1;
    pkt = '{32'hB6CF_1400, 32'h1, 32'h2, 32'h3, 32'h4};
    send_pkt();
    rd_all(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
